// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bus: stall/branch control in, instruction memory port, IF/ID slot out.
// The master modport belongs to the fetch stage; the slave side is the pipeline and memory environment.
interface instruction_fetch_stage_if;
  logic        stall;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic [31:0] imemAddr;
  logic        imemEn;
  logic [31:0] imemData;
  logic [31:0] instructionOUT;
  logic [31:0] pcValOUT;
  logic        noopOUT;

  modport master (
    input  stall,
    input  branchTaken,
    input  branchTarget,
    input  imemData,
    output imemAddr,
    output imemEn,
    output instructionOUT,
    output pcValOUT,
    output noopOUT
  );

  modport slave (
    output stall,
    output branchTaken,
    output branchTarget,
    output imemData,
    input  imemAddr,
    input  imemEn,
    input  instructionOUT,
    input  pcValOUT,
    input  noopOUT
  );
endinterface

// File: rtl/instruction_fetch_stage.sv
// ARM fetch stage: owns the PC, one fetch per cycle from a 1-cycle-latency memory; first word 2 cycles after reset.
// Stall freezes the slot (skid register keeps the word); a branch wins over stall and costs one bubble.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter logic [31:0] PC_READ_OFFSET = 32'd8
) (
  input logic                       clk,
  input logic                       reset,
  instruction_fetch_stage_if.master bus
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } slot_t;

  logic [31:0] fetch_pc;
  logic [31:0] resp_pc;
  logic        resp_valid;
  logic        hold_valid;
  slot_t       hold;

  logic [31:0] issue_addr;
  logic        issue;
  logic        noop;
  slot_t       out_slot;
  logic        unused_tgt_lsb;

  assign unused_tgt_lsb = ^bus.branchTarget[1:0];

  always_comb begin
    issue_addr = fetch_pc;
    if (bus.branchTaken) begin
      issue_addr = {bus.branchTarget[31:2], 2'b00};
    end
    issue = ~reset & (bus.branchTaken | ~bus.stall);
  end

  assign bus.imemAddr = issue_addr;
  assign bus.imemEn   = issue;

  // The skid slot takes priority: while it is full the memory data bus is stale.
  always_comb begin
    out_slot = hold_valid ? hold : slot_t'{instr: bus.imemData, pc: resp_pc};
    noop     = reset | bus.branchTaken | ~(hold_valid | resp_valid);
    bus.noopOUT        = noop;
    bus.instructionOUT = 32'd0;
    bus.pcValOUT       = 32'd0;
    if (!noop) begin
      bus.instructionOUT = out_slot.instr;
      bus.pcValOUT       = out_slot.pc + PC_READ_OFFSET;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc   <= RESET_PC;
      resp_valid <= 1'b0;
    end else if (issue) begin
      fetch_pc   <= issue_addr + 32'd4;
      resp_pc    <= issue_addr;
      resp_valid <= 1'b1;
    end
  end

  // Capture only on the first stalled cycle; the release cycle still drains from here.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid <= 1'b0;
    end else if (bus.branchTaken) begin
      hold_valid <= 1'b0;
    end else if (bus.stall) begin
      if (!hold_valid && resp_valid) begin
        hold       <= slot_t'{instr: bus.imemData, pc: resp_pc};
        hold_valid <= 1'b1;
      end
    end else begin
      hold_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: two instances (reset PC 0 and reset PC near the top of memory)
// share one directed stimulus stream and are checked every cycle against an architectural slot model.
module tb_instruction_fetch_stage;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [31:0] RPC0 = 32'h0000_0000;
  localparam logic [31:0] RPC1 = 32'hFFFF_FFF8;

  always #5 clk = ~clk;

  instruction_fetch_stage_if bus0();
  instruction_fetch_stage_if bus1();

  instruction_fetch_stage #(.RESET_PC(RPC0), .PC_READ_OFFSET(32'd8)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );
  instruction_fetch_stage #(.RESET_PC(RPC1), .PC_READ_OFFSET(32'd8)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1)
  );

  // Memory contents: word at byte address a holds a/4.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {2'b00, a[31:2]};
  endfunction

  // Synchronous memories; data after an idle cycle is deliberate garbage.
  always @(posedge clk) begin
    bus0.imemData <= bus0.imemEn ? memfn(bus0.imemAddr) : 32'hDEAD_BEEF;
    bus1.imemData <= bus1.imemEn ? memfn(bus1.imemAddr) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", nm, $time, act, exp);
    end
  endtask

  // Architectural model: the slot shown downstream is an address (or empty), plus the next sequential address.
  logic        m_valid [2];
  logic [31:0] m_cur   [2];
  logic [31:0] m_nxt   [2];

  initial begin
    m_valid[0] = 1'b0; m_cur[0] = 32'd0; m_nxt[0] = RPC0;
    m_valid[1] = 1'b0; m_cur[1] = 32'd0; m_nxt[1] = RPC1;
  end

  task automatic model_cycle(input int d, input logic st, input logic bt, input logic [31:0] tgt,
                             input logic a_en, input logic [31:0] a_addr, input logic a_noop,
                             input logic [31:0] a_instr, input logic [31:0] a_pc);
    logic [31:0] t;
    logic        e_en;
    logic        e_noop;
    string       p;
    p      = (d == 0) ? "dut0" : "dut1";
    t      = {tgt[31:2], 2'b00};
    e_en   = !reset && (bt || !st);
    e_noop = reset || bt || !m_valid[d];
    chk({p, " imemEn"}, {31'd0, a_en}, {31'd0, e_en});
    if (e_en) chk({p, " imemAddr"}, a_addr, bt ? t : m_nxt[d]);
    chk({p, " noopOUT"}, {31'd0, a_noop}, {31'd0, e_noop});
    chk({p, " instructionOUT"}, a_instr, e_noop ? 32'd0 : memfn(m_cur[d]));
    chk({p, " pcValOUT"}, a_pc, e_noop ? 32'd0 : m_cur[d] + 32'd8);
    if (reset) begin
      m_valid[d] = 1'b0;
      m_nxt[d]   = (d == 0) ? RPC0 : RPC1;
    end else if (bt) begin
      m_valid[d] = 1'b1;
      m_cur[d]   = t;
      m_nxt[d]   = t + 32'd4;
    end else if (!st) begin
      m_valid[d] = 1'b1;
      m_cur[d]   = m_nxt[d];
      m_nxt[d]   = m_nxt[d] + 32'd4;
    end
  endtask

  always @(negedge clk) begin
    model_cycle(0, bus0.stall, bus0.branchTaken, bus0.branchTarget,
                bus0.imemEn, bus0.imemAddr, bus0.noopOUT, bus0.instructionOUT, bus0.pcValOUT);
    model_cycle(1, bus1.stall, bus1.branchTaken, bus1.branchTarget,
                bus1.imemEn, bus1.imemAddr, bus1.noopOUT, bus1.instructionOUT, bus1.pcValOUT);
  end

  task automatic set_in(input logic r, input logic s, input logic b, input logic [31:0] t);
    reset             = r;
    bus0.stall        = s;
    bus0.branchTaken  = b;
    bus0.branchTarget = t;
    bus1.stall        = s;
    bus1.branchTaken  = b;
    bus1.branchTarget = t;
  endtask

  // One cycle: inputs change just after the edge, outputs are sampled at the falling edge.
  task automatic cyc(input logic r, input logic s, input logic b, input logic [31:0] t);
    @(posedge clk);
    #1;
    set_in(r, s, b, t);
    @(negedge clk);
  endtask

  initial begin
    set_in(1'b1, 1'b0, 1'b0, 32'd0);

    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 32'd0);
      chk("rst noop", {31'd0, bus0.noopOUT}, 32'd1);
      chk("rst en", {31'd0, bus0.imemEn}, 32'd0);
    end
    chk("rst instr", bus0.instructionOUT, 32'd0);
    chk("rst pc", bus0.pcValOUT, 32'd0);

    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    chk("c1 noop", {31'd0, bus0.noopOUT}, 32'd1);
    chk("c1 addr", bus0.imemAddr, 32'h0);
    chk("c1 wrap addr", bus1.imemAddr, 32'hFFFF_FFF8);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    chk("c2 instr", bus0.instructionOUT, 32'd0);
    chk("c2 pc", bus0.pcValOUT, 32'd8);
    chk("c2 addr", bus0.imemAddr, 32'd4);
    chk("c2 wrap addr", bus1.imemAddr, 32'hFFFF_FFFC);
    chk("c2 wrap pc", bus1.pcValOUT, 32'h0000_0000);
    chk("c2 wrap instr", bus1.instructionOUT, 32'h3FFF_FFFE);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    chk("c3 instr", bus0.instructionOUT, 32'd1);
    chk("c3 pc", bus0.pcValOUT, 32'd12);
    chk("c3 wrap addr", bus1.imemAddr, 32'h0000_0000);
    chk("c3 wrap pc", bus1.pcValOUT, 32'h0000_0004);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);

    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 32'd0);
      chk("stall instr", bus0.instructionOUT, 32'd4);
      chk("stall pc", bus0.pcValOUT, 32'h18);
    end
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    chk("release instr", bus0.instructionOUT, 32'd4);
    chk("release pc", bus0.pcValOUT, 32'h18);
    chk("release addr", bus0.imemAddr, 32'h14);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    chk("post stall instr", bus0.instructionOUT, 32'd5);
    chk("post stall pc", bus0.pcValOUT, 32'h1C);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);

    cyc(1'b0, 1'b0, 1'b1, 32'h103);
    chk("br noop", {31'd0, bus0.noopOUT}, 32'd1);
    chk("br addr", bus0.imemAddr, 32'h100);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    chk("br tgt instr", bus0.instructionOUT, 32'h40);
    chk("br tgt pc", bus0.pcValOUT, 32'h108);

    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    chk("hold instr", bus0.instructionOUT, 32'h41);
    cyc(1'b0, 1'b1, 1'b1, 32'h200);
    chk("br+stall noop", {31'd0, bus0.noopOUT}, 32'd1);
    chk("br+stall addr", bus0.imemAddr, 32'h200);
    chk("br+stall en", {31'd0, bus0.imemEn}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    chk("br+stall instr", bus0.instructionOUT, 32'h80);
    chk("br+stall pc", bus0.pcValOUT, 32'h208);

    cyc(1'b0, 1'b0, 1'b1, 32'h300);
    cyc(1'b0, 1'b0, 1'b1, 32'h400);
    chk("b2b noop", {31'd0, bus0.noopOUT}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    chk("b2b instr", bus0.instructionOUT, 32'h100);
    chk("b2b pc", bus0.pcValOUT, 32'h408);

    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    chk("pre-rst hold", bus0.instructionOUT, 32'h101);
    cyc(1'b0, 1'b1, 1'b0, 32'd0);
    cyc(1'b1, 1'b1, 1'b0, 32'd0);
    chk("rst-stall noop", {31'd0, bus0.noopOUT}, 32'd1);
    chk("rst-stall en", {31'd0, bus0.imemEn}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    chk("restart noop", {31'd0, bus0.noopOUT}, 32'd1);
    chk("restart addr", bus0.imemAddr, 32'h0);
    cyc(1'b0, 1'b0, 1'b0, 32'd0);
    chk("restart instr", bus0.instructionOUT, 32'd0);
    chk("restart pc", bus0.pcValOUT, 32'd8);

    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
